cbr_sequencer: RTL and testbench

- Producer side of the decode-to-CPU control command bus.
- Turns decoded control-flow ops (JMP/CALL/RET/HALT/SOFT_RST) into the 7-bit `decode2cpu_ctrl_cmd` that `cpu_control` consumes.
- Sequences CALL/RET as multi-cycle stack pushes/pops on a byte-wide memory port; releases `cpu_control` from its stack-op state by asserting `branch` with the resolved target.
- Owns the stack pointer.

---
 rtl/cbr_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_cbr_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cbr_sequencer.sv
// Control-flow command sequencer: turns decoded JMP/CALL/RET/HALT/SOFT_RST into cpu_control
// commands and runs CALL/RET as byte-wide stack accesses. Optional checks: CBR_STACK_CHECK_EN.
module cbr_sequencer #(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned STACK_PAGE = 0,
  parameter logic [7:0]  SP_INIT    = 8'hFF
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              dec_valid,
  input  logic [2:0]        dec_op,
  input  logic [ADDR_W-1:0] dec_target,
  input  logic [ADDR_W-1:0] pc_ret,
  input  logic              idecode_en,
  output logic [6:0]        decode2cpu_ctrl_cmd,
  output logic [ADDR_W-1:0] branch_target,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic [7:0]        sp,
  output logic              stack_err,
  output logic              busy
);

`ifdef CBR_STACK_CHECK_EN
  localparam bit CheckEn = 1'b1;
`else
  localparam bit CheckEn = 1'b0;
`endif

  localparam logic [ADDR_W-9:0] Page  = (ADDR_W-8)'(STACK_PAGE);
  localparam logic [7:0]        SpUfl = SP_INIT - 8'd2;

  // {call, branch, ret, soft_rst, halted, exec_en, fetch_en}
  localparam logic [6:0] CmdFetch  = 7'b0000001;
  localparam logic [6:0] CmdExec   = 7'b0000011;
  localparam logic [6:0] CmdHalt   = 7'b0000100;
  localparam logic [6:0] CmdSoft   = 7'b0001000;
  localparam logic [6:0] CmdRet    = 7'b0010000;
  localparam logic [6:0] CmdBranch = 7'b0100000;
  localparam logic [6:0] CmdCall   = 7'b1000000;

  localparam logic [2:0] OpJmp  = 3'b001;
  localparam logic [2:0] OpCall = 3'b010;
  localparam logic [2:0] OpRet  = 3'b011;
  localparam logic [2:0] OpHalt = 3'b100;
  localparam logic [2:0] OpSoft = 3'b101;

  typedef enum logic [2:0] {
    StIdle, StPushHi, StPushLo, StPopLo, StPopHi, StBranch, StHalt
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        sp_q, sp_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic [ADDR_W-1:0] ret_q, ret_d;
  logic [7:0]        mem_byte;
  logic              accept;
  logic              ovf, ufl;

  assign accept = dec_valid & idecode_en & (state_q == StIdle);
  assign ovf    = CheckEn && (sp_q <= 8'd1);
  assign ufl    = CheckEn && (sp_q > SpUfl);

  always_comb begin
    state_d             = state_q;
    sp_d                = sp_q;
    err_d               = err_q;
    tgt_d               = tgt_q;
    ret_d               = ret_q;
    decode2cpu_ctrl_cmd = CmdFetch;
    branch_target       = tgt_q;
    mem_req             = 1'b0;
    mem_we              = 1'b0;
    mem_byte            = sp_q;
    mem_wdata           = 8'h00;

    case (state_q)
      StIdle: begin
        if (accept) begin
          case (dec_op)
            OpJmp: begin
              decode2cpu_ctrl_cmd = CmdBranch;
              branch_target       = dec_target;
            end
            OpCall: begin
              if (ovf) begin
                decode2cpu_ctrl_cmd = CmdHalt;
                err_d               = 1'b1;
                state_d             = StHalt;
              end else begin
                decode2cpu_ctrl_cmd = CmdCall;
                tgt_d               = dec_target;
                ret_d               = pc_ret;
                state_d             = StPushHi;
              end
            end
            OpRet: begin
              if (ufl) begin
                decode2cpu_ctrl_cmd = CmdHalt;
                err_d               = 1'b1;
                state_d             = StHalt;
              end else begin
                decode2cpu_ctrl_cmd = CmdRet;
                state_d             = StPopLo;
              end
            end
            OpHalt: begin
              decode2cpu_ctrl_cmd = CmdHalt;
              state_d             = StHalt;
            end
            OpSoft: begin
              decode2cpu_ctrl_cmd = CmdSoft;
              sp_d                = SP_INIT;
              err_d               = 1'b0;
            end
            default: decode2cpu_ctrl_cmd = CmdExec;
          endcase
        end
      end
      StPushHi: begin
        decode2cpu_ctrl_cmd = CmdCall;
        mem_req             = 1'b1;
        mem_we              = 1'b1;
        mem_wdata           = 8'(ret_q >> 8);
        if (mem_ack) begin
          sp_d    = sp_q - 8'd1;
          state_d = StPushLo;
        end
      end
      StPushLo: begin
        decode2cpu_ctrl_cmd = CmdCall;
        mem_req             = 1'b1;
        mem_we              = 1'b1;
        mem_wdata           = ret_q[7:0];
        if (mem_ack) begin
          sp_d    = sp_q - 8'd1;
          state_d = StBranch;
        end
      end
      StPopLo: begin
        decode2cpu_ctrl_cmd = CmdRet;
        mem_req             = 1'b1;
        mem_byte            = sp_q + 8'd1;
        if (mem_ack) begin
          tgt_d[7:0] = mem_rdata;
          sp_d       = sp_q + 8'd1;
          state_d    = StPopHi;
        end
      end
      StPopHi: begin
        decode2cpu_ctrl_cmd = CmdRet;
        mem_req             = 1'b1;
        mem_byte            = sp_q + 8'd1;
        if (mem_ack) begin
          // High byte lands above the low byte already popped; excess bits drop off.
          tgt_d   = ADDR_W'({mem_rdata, tgt_q[7:0]});
          sp_d    = sp_q + 8'd1;
          state_d = StBranch;
        end
      end
      StBranch: begin
        decode2cpu_ctrl_cmd = CmdBranch;
        state_d             = StIdle;
      end
      StHalt: decode2cpu_ctrl_cmd = CmdHalt;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q <= StIdle;
      sp_q    <= SP_INIT;
      err_q   <= 1'b0;
      tgt_q   <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
      tgt_q   <= tgt_d;
      ret_q   <= ret_d;
    end
  end

  assign mem_addr  = {Page, mem_byte};
  assign sp        = sp_q;
  assign stack_err = err_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_cbr_sequencer.sv
// Scoreboard bench for cbr_sequencer: expected stack accesses and branch targets are queued
// by the stimulus and consumed by an independent monitor; cycle-level commands checked inline.
module tb_cbr_sequencer;
  logic        clk = 1'b0;
  logic        reset_;
  logic        dec_valid;
  logic [2:0]  dec_op;
  logic [11:0] dec_target;
  logic [11:0] pc_ret;
  logic        idecode_en;
  logic [6:0]  cmd;
  logic [11:0] branch_target;
  logic        mem_req, mem_we, mem_ack;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic [7:0]  sp;
  logic        stack_err, busy;

  int tests = 0;
  int fails = 0;
  int lat   = 0;
  logic [7:0] mem [256];

  typedef struct packed {
    logic        is_mem;
    logic        we;
    logic [7:0]  addr;
    logic [7:0]  data;
    logic [11:0] tgt;
  } ev_t;
  ev_t exp_q[$];

  always #5 clk = ~clk;

  cbr_sequencer dut (
    .clk                 (clk),
    .reset_              (reset_),
    .dec_valid           (dec_valid),
    .dec_op              (dec_op),
    .dec_target          (dec_target),
    .pc_ret              (pc_ret),
    .idecode_en          (idecode_en),
    .decode2cpu_ctrl_cmd (cmd),
    .branch_target       (branch_target),
    .mem_req             (mem_req),
    .mem_we              (mem_we),
    .mem_addr            (mem_addr),
    .mem_wdata           (mem_wdata),
    .mem_rdata           (mem_rdata),
    .mem_ack             (mem_ack),
    .sp                  (sp),
    .stack_err           (stack_err),
    .busy                (busy)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [11:0] tgt,
                       input logic [11:0] pr);
    @(posedge clk);
    #1;
    dec_valid  = v;
    dec_op     = op;
    dec_target = tgt;
    pc_ret     = pr;
    idecode_en = 1'b1;
  endtask

  task automatic push_mem(input logic we, input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back('{is_mem: 1'b1, we: we, addr: a, data: d, tgt: 12'h000});
  endtask

  task automatic push_br(input logic [11:0] t);
    exp_q.push_back('{is_mem: 1'b0, we: 1'b0, addr: 8'h00, data: 8'h00, tgt: t});
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 30);
    chk(nm, busy, 1'b0);
  endtask

  // Stack memory responder: acks after `lat` wait cycles.
  initial begin
    int wcnt = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (reset_ && mem_req) begin
        if (wcnt >= lat) begin
          mem_ack   = 1'b1;
          mem_rdata = mem[mem_addr[7:0]];
          if (mem_we) mem[mem_addr[7:0]] = mem_wdata;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
      @(posedge clk);
      #1 mem_ack = 1'b0;
    end
  end

  // Monitor: every completed stack access or branch cycle consumes one expected event.
  initial begin
    ev_t  e;
    logic is_mem_now;
    forever begin
      @(negedge clk);
      #1;
      if (reset_ && ((mem_req && mem_ack) || cmd[5])) begin
        is_mem_now = mem_req && mem_ack;
        if (exp_q.size() == 0) begin
          chk("unexpected_event", {is_mem_now, mem_addr}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("event_kind", is_mem_now, e.is_mem);
          if (is_mem_now) begin
            chk("mem_we", mem_we, e.we);
            chk("mem_addr", mem_addr, {4'h0, e.addr});
            if (e.we) chk("mem_wdata", mem_wdata, e.data);
          end else begin
            chk("branch_target", branch_target, e.tgt);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    reset_     = 1'b0;
    dec_valid  = 1'b0;
    dec_op     = 3'd0;
    dec_target = 12'h000;
    pc_ret     = 12'h000;
    idecode_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_cmd", cmd, 7'b0000001);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sp", sp, 8'hFF);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_target", branch_target, 12'h000);
    chk("rst_err", stack_err, 1'b0);
    @(posedge clk);
    #1 reset_ = 1'b1;

    // NORMAL and reserved opcodes
    drive(1'b1, 3'd0, 12'h0, 12'h0);
    @(negedge clk) chk("normal_cmd", cmd, 7'b0000011);
    drive(1'b1, 3'd6, 12'h0, 12'h0);
    @(negedge clk) chk("op110_cmd", cmd, 7'b0000011);
    drive(1'b1, 3'd1, 12'hABC, 12'h0);
    idecode_en = 1'b0;
    @(negedge clk) chk("no_run_cmd", cmd, 7'b0000001);
    drive(1'b0, 3'd0, 12'h0, 12'h0);
    @(negedge clk);
    chk("idle_cmd", cmd, 7'b0000001);
    chk("idle_sp", sp, 8'hFF);

    // CALL, zero-wait memory; a JMP held on the bus while busy must be ignored
    lat = 0;
    push_mem(1'b1, 8'hFF, 8'h01);
    push_mem(1'b1, 8'hFE, 8'h23);
    push_br(12'h345);
    drive(1'b1, 3'd2, 12'h345, 12'h123);
    @(negedge clk) chk("call_t0", cmd, 7'b1000000);
    drive(1'b1, 3'd1, 12'hABC, 12'h0);
    @(negedge clk);
    chk("call_t1", cmd, 7'b1000000);
    chk("call_busy", busy, 1'b1);
    @(negedge clk) chk("call_t2", cmd, 7'b1000000);
    @(negedge clk);
    chk("call_t3", cmd, 7'b0100000);
    chk("call_t3_tgt", branch_target, 12'h345);
    drive(1'b0, 3'd0, 12'h0, 12'h0);
    @(negedge clk);
    chk("call_t4", cmd, 7'b0000001);
    chk("call_sp", sp, 8'hFD);

    // RET with one wait state per access
    lat = 1;
    push_mem(1'b0, 8'hFE, 8'h00);
    push_mem(1'b0, 8'hFF, 8'h00);
    push_br(12'h123);
    drive(1'b1, 3'd3, 12'h0, 12'h0);
    @(negedge clk) chk("ret_t0", cmd, 7'b0010000);
    drive(1'b0, 3'd0, 12'h0, 12'h0);
    @(negedge clk);
    chk("ret_t1", cmd, 7'b0010000);
    n = 1;
    while (!cmd[5] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ret_branch_cycle", n, 5);
    chk("ret_tgt", branch_target, 12'h123);
    @(negedge clk);
    chk("ret_idle", cmd, 7'b0000001);
    chk("ret_sp", sp, 8'hFF);

    // JMP
    lat = 0;
    push_br(12'hABC);
    drive(1'b1, 3'd1, 12'hABC, 12'h0);
    @(negedge clk);
    chk("jmp_cmd", cmd, 7'b0100000);
    chk("jmp_tgt", branch_target, 12'hABC);
    chk("jmp_mem_req", mem_req, 1'b0);
    drive(1'b0, 3'd0, 12'h0, 12'h0);
    @(negedge clk) chk("jmp_after", cmd, 7'b0000001);

    // CALL then SOFT_RST restores SP
    push_mem(1'b1, 8'hFF, 8'h04);
    push_mem(1'b1, 8'hFE, 8'h56);
    push_br(12'h200);
    drive(1'b1, 3'd2, 12'h200, 12'h456);
    drive(1'b0, 3'd0, 12'h0, 12'h0);
    wait_idle("call2_idle");
    chk("call2_sp", sp, 8'hFD);
    drive(1'b1, 3'd5, 12'h0, 12'h0);
    @(negedge clk) chk("soft_cmd", cmd, 7'b0001000);
    drive(1'b0, 3'd0, 12'h0, 12'h0);
    @(negedge clk);
    chk("soft_sp", sp, 8'hFF);
    chk("soft_busy", busy, 1'b0);

`ifdef CBR_STACK_CHECK_EN
    // RET on empty stack is an underflow
    drive(1'b1, 3'd3, 12'h0, 12'h0);
    @(negedge clk);
    chk("ufl_cmd", cmd, 7'b0000100);
    chk("ufl_mem_req", mem_req, 1'b0);
    drive(1'b1, 3'd5, 12'h0, 12'h0);
    @(negedge clk) chk("ufl_err", stack_err, 1'b1);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmd !== 7'b0000100 || mem_req !== 1'b0) bad++;
    end
    chk("ufl_halt_hold", bad, 0);
    #2 reset_ = 1'b0;
    #1;
    chk("ufl_rst_cmd", cmd, 7'b0000001);
    chk("ufl_rst_err", stack_err, 1'b0);
    @(posedge clk);
    #1 reset_ = 1'b1;
`endif

    // HALT op: sticks through SOFT_RST, cleared only by reset
    drive(1'b1, 3'd4, 12'h0, 12'h0);
    @(negedge clk) chk("halt_cmd", cmd, 7'b0000100);
    drive(1'b1, 3'd5, 12'h0, 12'h0);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (cmd !== 7'b0000100 || busy !== 1'b1) bad++;
    end
    chk("halt_hold", bad, 0);
    dec_valid = 1'b0;
    #2 reset_ = 1'b0;
    #1;
    chk("halt_rst_cmd", cmd, 7'b0000001);
    chk("halt_rst_busy", busy, 1'b0);
    @(posedge clk);
    #1 reset_ = 1'b1;

    // Reset during the PUSH_LO wait aborts the CALL
    lat = 3;
    push_mem(1'b1, 8'hFF, 8'h07);
    drive(1'b1, 3'd2, 12'h100, 12'h789);
    drive(1'b0, 3'd0, 12'h0, 12'h0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(mem_req && mem_addr[7:0] == 8'hFE) && n < 20);
    chk("reach_push_lo", mem_req && mem_addr[7:0] == 8'hFE, 1'b1);
    #2 reset_ = 1'b0;
    #1;
    chk("abort_mem_req", mem_req, 1'b0);
    chk("abort_cmd", cmd, 7'b0000001);
    @(posedge clk);
    #1 reset_ = 1'b1;
    @(negedge clk);
    chk("abort_sp", sp, 8'hFF);
    chk("abort_idle_cmd", cmd, 7'b0000001);

    repeat (3) @(negedge clk);
    chk("exp_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
